// File: rtl/spi_ram_master.sv
// spi_ram_master: host-side SPI master that turns one byte read/write request into SPI_Wrapper command frames.
// Optional address cache (skip repeated address frames) is built when SPI_ADDR_CACHE_EN is defined.
module spi_ram_master #(
  parameter int TAIL    = 3,
  parameter int GAP     = 1,
  parameter int RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       MOSI,
  output logic       SS_n,
  input  logic       MISO
);
  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_SHIFT, S_TAIL, S_RWAIT, S_RECV, S_DESEL, S_DONE
  } state_t;

  localparam logic [3:0] TAIL_LAST  = 4'(TAIL - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);
  localparam logic [3:0] RWAIT_LAST = 4'(RD_WAIT - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       r_second;
  logic       w_second_next;
  logic       w_accept;
  logic       w_hit;
  logic       r_op;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [9:0] w_frame;
  logic [3:0] w_bit_idx;
  logic       w_rd_data_frame;
  logic       r_ss_n;
  logic       r_mosi;
  logic       r_req_ready;
  logic       r_busy;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;
  logic [7:0] r_rx;
  logic       r_recv_act;

  // First frame carries the address, second carries write data or the read-data command.
  assign w_frame         = r_second ? {r_op, 1'b1, (r_op ? 8'h00 : r_wdata)}
                                    : {r_op, 1'b0, r_addr};
  assign w_bit_idx       = 4'd9 - r_cnt;
  assign w_rd_data_frame = r_second && r_op;

`ifdef SPI_ADDR_CACHE_EN
  logic [7:0] r_wr_addr_q;
  logic [7:0] r_rd_addr_q;
  logic       r_wr_vld;
  logic       r_rd_vld;

  assign w_hit = req_op ? (r_rd_vld && (r_rd_addr_q == req_addr))
                        : (r_wr_vld && (r_wr_addr_q == req_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr_q <= 8'h00;
      r_rd_addr_q <= 8'h00;
      r_wr_vld    <= 1'b0;
      r_rd_vld    <= 1'b0;
    end else if (r_state == S_SEL && !r_second) begin
      if (r_op) begin
        r_rd_addr_q <= r_addr;
        r_rd_vld    <= 1'b1;
      end else begin
        r_wr_addr_q <= r_addr;
        r_wr_vld    <= 1'b1;
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_second <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_second <= w_second_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_second_next = r_second;
    w_accept      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_accept      = 1'b1;
          w_state_next  = S_SEL;
          w_cnt_next    = 4'd0;
          w_second_next = w_hit;
        end
      end
      S_SEL: begin
        w_state_next = S_SHIFT;
        w_cnt_next   = 4'd0;
      end
      S_SHIFT: begin
        if (r_cnt == 4'd9) begin
          w_cnt_next = 4'd0;
          if (w_rd_data_frame)
            w_state_next = (RD_WAIT == 0) ? S_RECV : S_RWAIT;
          else
            w_state_next = S_TAIL;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_TAIL: begin
        if (r_cnt == TAIL_LAST) begin
          w_cnt_next   = 4'd0;
          w_state_next = S_DESEL;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_RWAIT: begin
        if (r_cnt == RWAIT_LAST) begin
          w_cnt_next   = 4'd0;
          w_state_next = S_RECV;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_RECV: begin
        if (r_cnt == 4'd7) begin
          w_cnt_next   = 4'd0;
          w_state_next = S_DESEL;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_DESEL: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_next = 4'd0;
          if (!r_second) begin
            w_second_next = 1'b1;
            w_state_next  = S_SEL;
          end else begin
            w_state_next = S_DONE;
          end
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pins are registered decodes of the state, so the wire view trails the FSM by one cycle;
  // MISO is sampled in that same delayed window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_rx        <= 8'h00;
      r_recv_act  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      r_ss_n      <= !(r_state inside {S_SEL, S_SHIFT, S_TAIL, S_RWAIT, S_RECV});
      r_mosi      <= (r_state == S_SEL)   ? w_frame[9] :
                     (r_state == S_SHIFT) ? w_frame[w_bit_idx] : 1'b0;
      r_recv_act  <= (r_state == S_RECV);
      if (r_recv_act)
        r_rx <= {r_rx[6:0], MISO};
      r_rsp_valid <= (r_state == S_DONE);
      if (r_state == S_DONE)
        r_rsp_rdata <= r_op ? r_rx : 8'h00;
      r_req_ready <= (w_state_next == S_IDLE);
      r_busy      <= (w_state_next != S_IDLE) || (r_state == S_DONE);
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign MOSI      = r_mosi;
  assign SS_n      = r_ss_n;
endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: directed bench with a behavioural SPI_Wrapper slave and a frame/latency monitor.
module tb_spi_ram_master;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_op = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       MISO = 1'b0;
  logic       req_ready, rsp_valid, busy, MOSI, SS_n;
  logic [7:0] rsp_rdata;

  spi_ram_master dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and monitor, evaluated mid-cycle on the wire view.
  logic [7:0] mem [256];
  logic [9:0] sl_sr = 10'h000;
  logic [7:0] sl_addr = 8'h00, sl_raddr = 8'h00, sl_tx = 8'h00;
  bit         sl_send = 1'b0;
  int         sl_cnt = 0;
  logic [9:0] frames[$];
  int         lens[$], falls[$], rises[$], acc_cycs[$];
  logic [7:0] rsp_data[$];
  int         n_acc = 0, n_rsp = 0, acc_cyc = 0, last_lat = 0;

  always @(negedge clk) begin
    if (req_valid && req_ready && rst_n) begin
      acc_cyc = cyc + 1;
      acc_cycs.push_back(cyc + 1);
      n_acc++;
    end
    if (rsp_valid) begin
      last_lat = cyc - acc_cyc;
      rsp_data.push_back(rsp_rdata);
      n_rsp++;
    end
    if (!SS_n) begin
      if (sl_cnt == 0) falls.push_back(cyc);
      sl_cnt++;
      if (sl_cnt >= 2 && sl_cnt <= 11) sl_sr = {sl_sr[8:0], MOSI};
      if (sl_cnt == 11) begin
        frames.push_back(sl_sr);
        case (sl_sr[9:8])
          2'b00: sl_addr = sl_sr[7:0];
          2'b01: mem[sl_addr] = sl_sr[7:0];
          2'b10: sl_raddr = sl_sr[7:0];
          default: begin sl_tx = mem[sl_raddr]; sl_send = 1'b1; end
        endcase
      end
      if (sl_send && sl_cnt >= 14 && sl_cnt <= 21) MISO = sl_tx[21 - sl_cnt];
      else MISO = 1'($urandom);
    end else begin
      if (sl_cnt > 0) begin
        rises.push_back(cyc);
        lens.push_back(sl_cnt);
      end
      sl_cnt = 0;
      sl_send = 1'b0;
      MISO = 1'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  int fb, lb, rb, rsp_base;

  task automatic send_req(input logic op, input logic [7:0] a, input logic [7:0] d);
    int t;
    t = 0;
    @(posedge clk); #1;
    fb = frames.size(); lb = lens.size(); rb = rsp_data.size(); rsp_base = n_rsp;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    while (!req_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = ~op; req_addr = ~a; req_wdata = ~d;
  endtask

  task automatic wait_rsp(input string tag);
    int t;
    t = 0;
    while (n_rsp < rsp_base + 1 && t < 300) begin @(posedge clk); t++; end
    repeat (4) @(posedge clk);
    check({tag, "_rsp_pulses"}, n_rsp - rsp_base, 1);
  endtask

  initial begin
    int t;
    int a0;
    fork
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_ss_n", SS_n, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    check("rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;

    // Write FC <- B1, MISO randomised outside RECV
    send_req(1'b0, 8'hFC, 8'hB1);
    #1 check("wr_busy", busy, 1);
    wait_rsp("wr");
    check("wr_frame0", frames[fb], 10'h0FC);
    check("wr_frame1", frames[fb + 1], 10'h1B1);
    check("wr_len0", lens[lb], 14);
    check("wr_len1", lens[lb + 1], 14);
    check("wr_gap", falls[lb + 1] - rises[lb], 1);
    check("wr_latency", last_lat, 31);
    check("wr_rdata", rsp_data[rb], 8'h00);
    check("wr_busy_after", busy, 0);

    // Read FC back
    send_req(1'b1, 8'hFC, 8'h00);
    wait_rsp("rd");
    check("rd_frame0", frames[fb], 10'h2FC);
    check("rd_frame1", frames[fb + 1], 10'h300);
    check("rd_len1", lens[lb + 1], 21);
    check("rd_latency", last_lat, 38);
    check("rd_rdata", rsp_data[rb], 8'hB1);

    // Held request: two reads back to back
    send_req(1'b0, 8'h10, 8'h5A); wait_rsp("pre10");
    send_req(1'b0, 8'h20, 8'hA5); wait_rsp("pre20");
    @(posedge clk); #1;
    rb = rsp_data.size(); a0 = acc_cycs.size(); rsp_base = n_rsp;
    req_valid = 1'b1; req_op = 1'b1; req_addr = 8'h10;
    t = 0;
    while (n_acc < a0 + 1 && t < 100) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    req_addr = 8'h20;
    t = 0;
    while (n_acc < a0 + 2 && t < 200) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    t = 0;
    while (n_rsp < rsp_base + 2 && t < 200) begin @(posedge clk); t++; end
    repeat (4) @(posedge clk);
    check("held_acc_count", acc_cycs.size() - a0, 2);
    check("held_acc_spacing", acc_cycs[a0 + 1] - acc_cycs[a0], 39);
    check("held_rsp_count", n_rsp - rsp_base, 2);
    check("held_rdata0", rsp_data[rb], 8'h5A);
    check("held_rdata1", rsp_data[rb + 1], 8'hA5);

    // Reset at the 5th SHIFT bit of a write
    send_req(1'b0, 8'h5E, 8'h77);
    repeat (6) @(posedge clk);
    #2 check("mid_ss_low", SS_n, 0);
    rst_n = 1'b0;
    #1;
    check("arst_ss_n", SS_n, 1);
    check("arst_mosi", MOSI, 0);
    check("arst_req_ready", req_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_req(1'b0, 8'h44, 8'h3C);
    wait_rsp("post_rst_wr");
    check("post_rst_frame0", frames[fb], 10'h044);
    check("post_rst_frame1", frames[fb + 1], 10'h13C);
    check("post_rst_latency", last_lat, 31);
    send_req(1'b1, 8'h44, 8'h00);
    wait_rsp("post_rst_rd");
    check("post_rst_rdata", rsp_data[rb], 8'h3C);

    // Repeated write address
    send_req(1'b0, 8'h33, 8'h11); wait_rsp("c_wr1");
    send_req(1'b0, 8'h33, 8'h22); wait_rsp("c_wr2");
`ifdef SPI_ADDR_CACHE_EN
    check("c_wr2_nframes", frames.size() - fb, 1);
    check("c_wr2_frame", frames[fb], 10'h122);
    check("c_wr2_latency", last_lat, 16);
`else
    check("c_wr2_nframes", frames.size() - fb, 2);
    check("c_wr2_frame", frames[fb + 1], 10'h122);
    check("c_wr2_latency", last_lat, 31);
`endif
    send_req(1'b1, 8'h33, 8'h00); wait_rsp("c_rd");
    check("c_rd_frame0", frames[fb], 10'h233);
    check("c_rd_frame1", frames[fb + 1], 10'h300);
    check("c_rd_rdata", rsp_data[rb], 8'h22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
- Host-side SPI master that sequences complete RAM transactions into the SPI_Wrapper slave over MOSI/SS_n/MISO.
- Converts one host request (byte write or byte read at an 8-bit address) into the wrapper's 10-bit command frames: 2'b00 write-address, 2'b01 write-data, 2'b10 read-address, 2'b11 read-data.
- Returns read data to the host and sits between a CPU/bus adapter and SPI_Wrapper on the same clk.

Parameters:
- TAIL, 3, cycles SS_n is held low after the last MOSI bit of a non-read-data frame (1..15).
- GAP, 1, cycles SS_n is held high between frames and after a transaction (1..15).
- RD_WAIT, 2, cycles between the last read-data command bit and the first MISO data bit (0..15).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  host request strobe.
- req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready.
- req_op  in  1  0=write, 1=read.
- req_addr  in  8  RAM address.
- req_wdata  in  8  write data (ignored for reads).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read byte; 8'h00 for writes; held until next completion.
- busy  out  1  high from acceptance until the rsp_valid cycle inclusive.
- MOSI  out  1  serial data to slave.
- SS_n  out  1  slave select, active low.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset (async, any state): SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, state=IDLE. SS_n rises immediately, aborting any frame.
- All outputs are registered. A value driven after posedge k is sampled by the slave at posedge k+1.
- On acceptance, latch op/addr/wdata; later input changes are ignored.
- Frame list:
  - write: {2'b00,addr} then {2'b01,wdata}
  - read: {2'b10,addr} then {2'b11,8'h00}
- States:
  - IDLE: SS_n=1, MOSI=0. Accept request, go to SEL.
  - SEL: 1 cycle. SS_n=0, MOSI=frame[9] (cmd select bit). Go to SHIFT.
  - SHIFT: 10 cycles. MOSI=frame[9] down to frame[0], MSB first, 4-bit counter. For a read-data frame go to RWAIT, otherwise TAIL.
  - TAIL: TAIL cycles. SS_n=0, MOSI=0. Go to DESEL.
  - RWAIT: RD_WAIT cycles. SS_n=0, MOSI=0. Go to RECV.
  - RECV: 8 cycles. Shift MISO into an 8-bit register MSB first, sampled on posedge. Go to DESEL.
  - DESEL: GAP cycles with SS_n=1. If a second frame is pending go to SEL, else go to DONE.
  - DONE: 1 cycle. rsp_valid=1, rsp_rdata updated (reads only). Go to IDLE; req_ready=1 the following cycle.
- Timing with defaults:
  - Write: SS_n low 14 cycles per frame. Acceptance to rsp_valid = 1+14+1+14+1 = 31 cycles.
  - Read: second frame holds SS_n low 1+10+2+8 = 21 cycles.
- A request held during busy is not accepted. No back-to-back acceptance in the DONE cycle.
- MISO is ignored outside RECV.

Optional Feature:
- Macro SPI_ADDR_CACHE_EN.
- Defined:
  - Keeps wr_addr_q/rd_addr_q with valid bits, cleared on reset.
  - A write whose addr equals a valid wr_addr_q skips the 2'b00 frame. Same for reads with rd_addr_q and the 2'b10 frame.
  - Each address frame sent updates the matching cache entry.
  - Write latency drops to 16 cycles on a hit (defaults).
- Undefined: both frames are always sent; no extra registers.

Test Plan:
- Write addr=8'hFC data=8'hB1 -> MOSI streams 10'h0FC then 10'h1B1. SS_n low 14 cycles each, 1-cycle high gap. rsp_valid 31 cycles after acceptance, rsp_rdata=8'h00.
- Write addr=8'hFC data=8'hB1, then read addr=8'hFC with a bench SPI_Wrapper -> frames 10'h2FC, 10'h300 sent; rsp_rdata=8'hB1 with a single rsp_valid pulse.
- Hold req_valid high with two reads to 8'h10 and 8'h20 (slave returns 8'h5A, 8'hA5) -> second request accepted only after DONE; responses 8'h5A then 8'hA5 in order.
- Assert rst_n=0 at the 5th SHIFT bit of a write -> SS_n=1 the same cycle, outputs at reset values. A fresh write afterwards completes correctly.
- Toggle MISO randomly outside RECV during a write -> rsp_rdata stays 8'h00.
- SPI_ADDR_CACHE_EN: two writes to 8'h33 -> second write sends only 10'h1xx, rsp_valid 16 cycles after acceptance. A following read to 8'h33 still sends 10'h233.
